// File: rtl/rx_sr_pkg.sv
// ============================================================================
// rx_sr_pkg : shared types and frame-size helper for the UART receive path.
// Rev 1.0
// ============================================================================
`default_nettype none

package rx_sr_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } par_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } rx_state_e;

   function automatic int frame_bits(input int data_bits, input int parity_mode,
                                     input int stop_bits);
      return data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bit_cnt.sv
// ============================================================================
// rx_bit_cnt : bit counter with clear, enable and a wrap flag at wrap_val.
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_bit_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] wrap_val,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Flag is qualified by en so it marks the strobe that completes the count.
   assign wrap = en && (cnt_q == wrap_val);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

`default_nettype wire

// File: rtl/rx_frame_sr.sv
// ============================================================================
// rx_frame_sr : parametrised UART receive-frame shift register with parity,
// framing and overrun checks. Optional macro RX_BREAK_DETECT_EN adds break_det.
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_frame_sr
   import rx_sr_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic                 shift_strobe,
   input  logic                 serial_in,
   input  logic                 data_ready,
   output logic [DATA_BITS-1:0] packet_data,
   output logic                 data_valid,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun_error,
   output logic                 busy
`ifdef RX_BREAK_DETECT_EN
  ,output logic                 break_det
`endif
);

   localparam int        FB    = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
   localparam int        CNT_W = $clog2(FB);
   localparam par_mode_e PMODE = par_mode_e'(2'(PARITY_MODE));

   rx_state_e            state_q, state_d;
   logic [FB-1:0]        sr_q, sr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 ovr_q, ovr_d;

   logic                 cnt_clr, cnt_en, cnt_wrap;
   logic [DATA_BITS-1:0] frm_data;
   logic                 frm_par;
   logic [STOP_BITS-1:0] frm_stop;
   logic                 frm_fe, frm_pe, frm_break;

   rx_bit_cnt #(
      .WIDTH (CNT_W)
   ) u_bit_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .wrap_val (CNT_W'(FB - 1)),
      .wrap     (cnt_wrap)
   );

   // Frame fields are only meaningful while the FSM sits in DONE.
   assign frm_data = sr_q[DATA_BITS-1:0];
   assign frm_par  = sr_q[DATA_BITS];
   assign frm_stop = sr_q[FB-1 -: STOP_BITS];
   assign frm_fe   = ~&frm_stop;
   assign frm_pe   = (PMODE == PAR_NONE) ? 1'b0
                   : ((^frm_data ^ frm_par) != (PMODE == PAR_ODD));

`ifdef RX_BREAK_DETECT_EN
   assign frm_break = (sr_q == '0);
   assign break_det = (state_q == DONE) && frm_break;
`else
   assign frm_break = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = SHIFT;
               cnt_clr = 1'b1;
            end
         end
         SHIFT: begin
            if (shift_strobe) begin
               cnt_en = 1'b1;
               sr_d   = {serial_in, sr_q[FB-1:1]};
               if (cnt_wrap)
                  state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake clear is applied first so a same-edge load overrides it.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ovr_d   = ovr_q;
      if (valid_q && data_ready) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if ((state_q == DONE) && !frm_break) begin
         if (!valid_q || data_ready) begin
            data_d  = frm_data;
            pe_d    = frm_pe;
            fe_d    = frm_fe;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '1;
         data_q  <= '0;
         valid_q <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
      end
   end

   assign packet_data   = data_q;
   assign data_valid    = valid_q;
   assign parity_error  = pe_q;
   assign framing_error = fe_q;
   assign overrun_error = ovr_q;
   assign busy          = (state_q == SHIFT);

endmodule

`default_nettype wire

// File: doc/rx_frame_sr.md
Name: rx_frame_sr

Overview:
Parametrised receive-frame shift register for the UART receiver datapath. Generalises the fixed 9-bit data+stop register to configurable data width, parity and stop-bit count. Adds a bit counter, a frame FSM, parity/framing checks and a valid/ready output holding register. Sits between the start-bit detector/timer (frame_start, shift_strobe) and the RX FIFO/bus interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
frame_start  in  1  one-cycle pulse from the start-bit detector at the start-bit centre.
shift_strobe  in  1  one-cycle pulse: sample serial_in.
serial_in  in  1  serial line; idles at 1.
data_ready  in  1  consumer accepts data this cycle.
packet_data  out  DATA_BITS  received data, LSB = first bit received.
data_valid  out  1  packet_data and flags are valid; held until accepted.
parity_error  out  1  parity mismatch for the held frame; 0 when PARITY_MODE = 0.
framing_error  out  1  at least one stop bit of the held frame was 0.
overrun_error  out  1  sticky; a completed frame was dropped because data_valid was still held.
busy  out  1  FSM is in SHIFT.

Behaviour:
- Reset (async, active-high): FSM to IDLE; bit counter to 0; shift register to all 1s; all outputs to 0.
- FRAME_BITS = DATA_BITS + (PARITY_MODE != 0) + STOP_BITS. The shift register is FRAME_BITS wide and shifts right; serial_in enters the MSB.
- IDLE:
  - shift_strobe is ignored.
  - frame_start moves the FSM to SHIFT and clears the counter.
- SHIFT:
  - Each shift_strobe shifts once and increments the counter.
  - frame_start is ignored.
  - On the strobe where the counter reaches FRAME_BITS-1, the FSM moves to DONE at that edge. The last bit is shifted in on the same edge.
- DONE (one cycle):
  - Frame layout: data = sr[DATA_BITS-1:0]; parity = sr[DATA_BITS] if enabled; stop bits = top STOP_BITS bits.
  - Checks: framing_error = any stop bit is 0. parity_error = (XOR of data ^ parity bit) != (PARITY_MODE == 2).
  - Delivery: if data_valid == 0, or data_ready == 1 in this cycle, load packet_data and both flags, and set data_valid = 1 at the next edge.
  - Otherwise drop the frame: held data is unchanged, overrun_error is set.
  - Return to IDLE.
- Latency: data_valid rises 2 clk edges after the final shift_strobe cycle (edge 1 enters DONE, edge 2 loads the outputs).
- Handshake: data_valid & data_ready at an edge clears data_valid and overrun_error. This happens in the same edge as any simultaneous load, and the load wins for data_valid.
- frame_start and shift_strobe in the same cycle while in IDLE: only frame_start acts; the strobe is not counted.
- rst mid-frame: the partial frame is discarded and no data_valid is raised.

Optional Feature:
Macro RX_BREAK_DETECT_EN.
- Defined: adds output break_det (1 bit). A frame of all zeros including stop bits pulses break_det high for exactly the DONE cycle. That frame is not delivered and sets neither overrun_error nor data_valid.
- Undefined: no break_det port; an all-zero frame is delivered normally with framing_error = 1.

Decomposition:
- Package rx_sr_pkg holds:
  - typedef enum for PARITY_MODE (PAR_NONE, PAR_EVEN, PAR_ODD);
  - typedef enum for the FSM state (IDLE, SHIFT, DONE);
  - function frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS).
- One sub-module, rx_bit_cnt: a parametrised counter with clear, enable and rollover-flag at a programmable value. It supplies the last-bit indication to the FSM.

Test Plan:
- 8N1, frame_start, then bits 1,0,1,0,0,1,0,1,1 on strobes -> packet_data = 0xA5, data_valid = 1 two edges after the last strobe, parity_error = framing_error = 0.
- DATA_BITS = 7, PARITY_MODE = 1, data 0x07 with parity bit 0, stop 1 -> packet_data = 0x07, parity_error = 1. Repeat with parity bit 1 -> parity_error = 0.
- 8N2, 0x3C with second stop bit 0 -> framing_error = 1, data_valid = 1.
- Two 8N1 frames 0x11 then 0x22 with data_ready held 0 -> packet_data stays 0x11 and overrun_error = 1. Then data_ready = 1 for one cycle -> data_valid = 0 and overrun_error = 0.
- Second frame completes in the same cycle data_ready = 1 -> 0x22 loaded, data_valid stays 1, overrun_error = 0.
- rst pulsed after 4 of 9 strobes, then a full 0x5A frame -> only 0x5A delivered, no error flags. With RX_BREAK_DETECT_EN and an all-zero 8N1 frame -> break_det pulses 1 cycle, data_valid stays 0.
